// File: rtl/mc_main_fsm.sv
// Main sequencing FSM for the multicycle ARMv4-subset core (fetch/decode/execute/memory/writeback).
// Define MC_FSM_WAIT_EN to add a mem_ready input that stalls FETCH, MEMRD and MEMWR.
module mc_main_fsm #(
  parameter bit          ILLEGAL_TRAP = 1'b0,
  parameter int unsigned STATE_W      = 4
) (
  input  logic               clk,
  input  logic               reset,
`ifdef MC_FSM_WAIT_EN
  input  logic               mem_ready,
`endif
  input  logic [1:0]         Op,
  input  logic [5:0]         Funct,
  output logic               IRWrite,
  output logic               NextPC,
  output logic               RegW,
  output logic               MemW,
  output logic               Branch,
  output logic               AdrSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic               ALUOp,
  output logic [STATE_W-1:0] state,
  output logic               retire,
  output logic               illegal
);

  localparam int unsigned ENC_W = 4;

  typedef enum logic [ENC_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_HALT   = 4'd10
  } state_t;

  state_t     r_state;
  state_t     w_next;
  state_t     w_dec_state;
  logic       w_ready;
  logic       w_hold;
  logic       w_go;
  logic       w_set_illegal;
  logic       w_gate;

  logic       r_irwrite, r_nextpc, r_regw, r_memw, r_branch, r_retire;
  logic       r_adrsrc, r_alusrca, r_aluop, r_gate, r_illegal;
  logic [1:0] r_alusrcb, r_resultsrc;

  logic       w_irwrite, w_nextpc, w_regw, w_memw, w_branch, w_retire;
  logic       w_adrsrc, w_alusrca, w_aluop;
  logic [1:0] w_alusrcb, w_resultsrc;

`ifdef MC_FSM_WAIT_EN
  assign w_ready = mem_ready;
`else
  assign w_ready = 1'b1;
`endif

  // r_gate marks the memory-access states that wait for mem_ready
  assign w_hold = r_gate & ~w_ready;

  // Next-state selection; Op/Funct only matter in DECODE and MEMADR
  always_comb begin
    w_next        = S_FETCH;
    w_set_illegal = 1'b0;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b00:   w_next = Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          2'b11: begin
            w_set_illegal = 1'b1;
            w_next        = ILLEGAL_TRAP ? S_HALT : S_FETCH;
          end
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = S_MEMWB;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  w_next = S_FETCH;
      S_EXECR:  w_next = S_ALUWB;
      S_EXECI:  w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_FETCH;
    endcase
    if (w_hold) begin
      w_next = r_state;
    end
  end

  assign w_dec_state = reset ? w_next : S_FETCH;

  // Moore output decode of the state about to be entered, so outputs come straight from flops
  always_comb begin
    w_irwrite   = 1'b0;
    w_nextpc    = 1'b0;
    w_regw      = 1'b0;
    w_memw      = 1'b0;
    w_branch    = 1'b0;
    w_retire    = 1'b0;
    w_adrsrc    = 1'b0;
    w_alusrca   = 1'b0;
    w_alusrcb   = 2'b00;
    w_resultsrc = 2'b00;
    w_aluop     = 1'b0;
    case (w_dec_state)
      S_FETCH: begin
        w_alusrca   = 1'b1;
        w_alusrcb   = 2'b10;
        w_resultsrc = 2'b10;
        w_irwrite   = 1'b1;
        w_nextpc    = 1'b1;
      end
      S_DECODE: begin
        w_alusrca   = 1'b1;
        w_alusrcb   = 2'b10;
        w_resultsrc = 2'b10;
      end
      S_MEMADR: begin
        w_alusrcb = 2'b01;
      end
      S_MEMRD: begin
        w_adrsrc = 1'b1;
      end
      S_MEMWB: begin
        w_resultsrc = 2'b01;
        w_regw      = 1'b1;
        w_retire    = 1'b1;
      end
      S_MEMWR: begin
        w_adrsrc = 1'b1;
        w_memw   = 1'b1;
        w_retire = 1'b1;
      end
      S_EXECR: begin
        w_aluop = 1'b1;
      end
      S_EXECI: begin
        w_alusrcb = 2'b01;
        w_aluop   = 1'b1;
      end
      S_ALUWB: begin
        w_regw   = 1'b1;
        w_retire = 1'b1;
      end
      S_BRANCH: begin
        w_alusrcb   = 2'b01;
        w_resultsrc = 2'b10;
        w_branch    = 1'b1;
        w_retire    = 1'b1;
      end
      S_HALT: begin
        w_alusrca   = 1'b1;
        w_alusrcb   = 2'b10;
        w_resultsrc = 2'b10;
      end
      default: ;
    endcase
  end

  assign w_gate = (w_dec_state == S_FETCH) || (w_dec_state == S_MEMRD) ||
                  (w_dec_state == S_MEMWR);

  // State, registered outputs and the sticky illegal flag
  always_ff @(posedge clk) begin
    r_state     <= w_dec_state;
    r_gate      <= w_gate;
    r_irwrite   <= w_irwrite;
    r_nextpc    <= w_nextpc;
    r_regw      <= w_regw;
    r_memw      <= w_memw;
    r_branch    <= w_branch;
    r_retire    <= w_retire;
    r_adrsrc    <= w_adrsrc;
    r_alusrca   <= w_alusrca;
    r_alusrcb   <= w_alusrcb;
    r_resultsrc <= w_resultsrc;
    r_aluop     <= w_aluop;
    if (!reset) begin
      r_illegal <= 1'b0;
    end else if (w_set_illegal) begin
      r_illegal <= 1'b1;
    end
  end

  // Strobes are suppressed during reset and while a memory state waits
  assign w_go = reset & (w_ready | ~r_gate);

  assign IRWrite   = r_irwrite & w_go;
  assign NextPC    = r_nextpc  & w_go;
  assign RegW      = r_regw    & w_go;
  assign MemW      = r_memw    & w_go;
  assign Branch    = r_branch  & w_go;
  assign retire    = r_retire  & w_go;
  assign AdrSrc    = r_adrsrc;
  assign ALUSrcA   = r_alusrca;
  assign ALUSrcB   = r_alusrcb;
  assign ResultSrc = r_resultsrc;
  assign ALUOp     = r_aluop;
  assign state     = STATE_W'(r_state);
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Bench for mc_main_fsm: two instances (ILLEGAL_TRAP 0 and 1) driven by directed then random
// instructions, checked every cycle against an instruction-plan model and fixed expectations.
module tb_mc_main_fsm;

`ifdef MC_FSM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'd0;
  logic       rdy = 1'b1;

  logic       irw[2], npc[2], regw[2], memw[2], br[2], ret[2];
  logic       adr[2], srca[2], aluop[2], ill_o[2];
  logic [1:0] srcb[2], res[2];
  logic [3:0] st[2];

  int n_tests = 0;
  int n_fail  = 0;

  // model: current state, pending plan of states, sticky illegal, expected latency
  int cur[2];
  int plan[2][4];
  int pn[2];
  int ill[2];
  int valid[2];
  int lat[2];
  int dcnt = 0;

  always #5 clk = ~clk;

  mc_main_fsm #(.ILLEGAL_TRAP(1'b0), .STATE_W(4)) dut0 (
    .clk(clk), .reset(reset),
`ifdef MC_FSM_WAIT_EN
    .mem_ready(rdy),
`endif
    .Op(Op), .Funct(Funct),
    .IRWrite(irw[0]), .NextPC(npc[0]), .RegW(regw[0]), .MemW(memw[0]), .Branch(br[0]),
    .AdrSrc(adr[0]), .ALUSrcA(srca[0]), .ALUSrcB(srcb[0]), .ResultSrc(res[0]),
    .ALUOp(aluop[0]), .state(st[0]), .retire(ret[0]), .illegal(ill_o[0])
  );

  mc_main_fsm #(.ILLEGAL_TRAP(1'b1), .STATE_W(4)) dut1 (
    .clk(clk), .reset(reset),
`ifdef MC_FSM_WAIT_EN
    .mem_ready(rdy),
`endif
    .Op(Op), .Funct(Funct),
    .IRWrite(irw[1]), .NextPC(npc[1]), .RegW(regw[1]), .MemW(memw[1]), .Branch(br[1]),
    .AdrSrc(adr[1]), .ALUSrcA(srca[1]), .ALUSrcB(srcb[1]), .ResultSrc(res[1]),
    .ALUOp(aluop[1]), .state(st[1]), .retire(ret[1]), .illegal(ill_o[1])
  );

  // {IRWrite,NextPC,RegW,MemW,Branch,retire, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp}
  function automatic logic [12:0] exp_out(input int s);
    case (s)
      0:  return {6'b110000, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0};
      1:  return {6'b000000, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0};
      2:  return {6'b000000, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0};
      3:  return {6'b000000, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0};
      4:  return {6'b001001, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0};
      5:  return {6'b000101, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0};
      6:  return {6'b000000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1};
      7:  return {6'b000000, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1};
      8:  return {6'b001001, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
      9:  return {6'b000011, 1'b0, 1'b0, 2'b01, 2'b10, 1'b0};
      10: return {6'b000000, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0};
      default: return 13'd0;
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int k, input int v);
    plan[k][pn[k]] = v;
    pn[k]++;
  endtask

  // Advance one instance of the model across a rising edge using the current inputs
  task automatic model_step(input int k, input int trap);
    int stall;
    if (!reset) begin
      cur[k] = 0; pn[k] = 0; ill[k] = 0; valid[k] = 1; lat[k] = 0;
      return;
    end
    if (valid[k] == 0) return;
    stall = (WAIT_EN && !rdy && (cur[k] == 0 || cur[k] == 3 || cur[k] == 5)) ? 1 : 0;
    if (stall != 0) begin
      if (cur[k] != 0) lat[k]++;
      return;
    end
    case (cur[k])
      0: begin lat[k] = 0; push(k, 1); end
      1: begin
        case (Op)
          2'b00: begin lat[k] = 4; push(k, Funct[5] ? 7 : 6); push(k, 8); end
          2'b01: push(k, 2);
          2'b10: begin lat[k] = 3; push(k, 9); end
          default: begin ill[k] = 1; if (trap != 0) push(k, 10); end
        endcase
      end
      2: begin
        if (Funct[0]) begin lat[k] = 5; push(k, 3); push(k, 4); end
        else begin lat[k] = 4; push(k, 5); end
      end
      10: push(k, 10);
      default: ;
    endcase
    if (pn[k] > 0) begin
      cur[k] = plan[k][0];
      for (int i = 0; i < 3; i++) plan[k][i] = plan[k][i+1];
      pn[k]--;
    end else begin
      cur[k] = 0;
    end
  endtask

  // Compare both instances against the model; called mid-cycle, away from the clock edge
  task automatic compare();
    logic [12:0] e;
    logic [12:0] o;
    for (int k = 0; k < 2; k++) begin
      o = {irw[k], npc[k], regw[k], memw[k], br[k], ret[k], adr[k], srca[k], srcb[k], res[k], aluop[k]};
      if (!reset) begin
        chk($sformatf("reset_strobes%0d", k), int'(o[12:7]), 0);
        if (valid[k] != 0) begin
          chk($sformatf("reset_state%0d", k), int'(st[k]), cur[k]);
          chk($sformatf("reset_illegal%0d", k), int'(ill_o[k]), ill[k]);
        end
      end else if (valid[k] != 0) begin
        e = exp_out(cur[k]);
        if (WAIT_EN && !rdy && (cur[k] == 0 || cur[k] == 5)) e[12:7] = e[12:7] & 6'b001010;
        chk($sformatf("outputs%0d", k), int'(o), int'(e));
        chk($sformatf("state%0d", k), int'(st[k]), cur[k]);
        chk($sformatf("illegal%0d", k), int'(ill_o[k]), ill[k]);
      end
    end
    // instruction latency on dut0: from the IRWrite cycle to the retire cycle inclusive
    if (reset) begin
      if (irw[0]) dcnt = 1;
      else if (dcnt > 0) dcnt++;
      if (ret[0]) begin
        if (dcnt > 0) chk("latency0", dcnt, lat[0]);
        dcnt = 0;
      end
    end else begin
      dcnt = 0;
    end
  endtask

  // One cycle: drive at negedge, check, then step the model at the rising edge
  task automatic cyc(input logic r, input logic [1:0] op, input logic [5:0] fn, input logic rd,
                     input int ls0, input int lsb, input int ls1);
    @(negedge clk);
    reset = r; Op = op; Funct = fn; rdy = rd;
    #1;
    compare();
    if (ls0 >= 0) chk("lit_state0", int'(st[0]), ls0);
    if (lsb >= 0) chk("lit_strobes0", int'({irw[0], npc[0], regw[0], memw[0], br[0], ret[0]}), lsb);
    if (ls1 >= 0) chk("lit_state1", int'(st[1]), ls1);
    @(posedge clk);
    model_step(0, 0);
    model_step(1, 1);
  endtask

  initial begin
    logic r;
    int   rst_left;
    int   pick;
    for (int k = 0; k < 2; k++) begin
      cur[k] = 0; pn[k] = 0; ill[k] = 0; valid[k] = 0; lat[k] = 0;
    end

    // reset held three cycles with Op=01
    cyc(1'b0, 2'b01, 6'd0, 1'b1, -1, 0, -1);
    cyc(1'b0, 2'b01, 6'd0, 1'b1, 0, 0, 0);
    cyc(1'b0, 2'b01, 6'd0, 1'b1, 0, 0, 0);

    // ADD immediate: 0,1,7,8
    cyc(1'b1, 2'b00, 6'b101000, 1'b1, 0, 6'b110000, 0);
    cyc(1'b1, 2'b00, 6'b101000, 1'b1, 1, 6'b000000, 1);
    cyc(1'b1, 2'b00, 6'b101000, 1'b1, 7, 6'b000000, 7);
    cyc(1'b1, 2'b00, 6'b101000, 1'b1, 8, 6'b001001, 8);
    // LDR: 0,1,2,3,4
    cyc(1'b1, 2'b01, 6'b011001, 1'b1, 0, 6'b110000, 0);
    cyc(1'b1, 2'b01, 6'b011001, 1'b1, 1, 6'b000000, 1);
    cyc(1'b1, 2'b01, 6'b011001, 1'b1, 2, 6'b000000, 2);
    cyc(1'b1, 2'b01, 6'b011001, 1'b1, 3, 6'b000000, 3);
    cyc(1'b1, 2'b01, 6'b011001, 1'b1, 4, 6'b001001, 4);
    // STR: 0,1,2,5
    cyc(1'b1, 2'b01, 6'b011000, 1'b1, 0, 6'b110000, 0);
    cyc(1'b1, 2'b01, 6'b011000, 1'b1, 1, 6'b000000, 1);
    cyc(1'b1, 2'b01, 6'b011000, 1'b1, 2, 6'b000000, 2);
    cyc(1'b1, 2'b01, 6'b011000, 1'b1, 5, 6'b000101, 5);
    // B: 0,1,9
    cyc(1'b1, 2'b10, 6'd0, 1'b1, 0, 6'b110000, 0);
    cyc(1'b1, 2'b10, 6'd0, 1'b1, 1, 6'b000000, 1);
    cyc(1'b1, 2'b10, 6'd0, 1'b1, 9, 6'b000011, 9);
    // Op=11: dut0 back to FETCH, dut1 halts
    cyc(1'b1, 2'b11, 6'd0, 1'b1, 0, 6'b110000, 0);
    cyc(1'b1, 2'b11, 6'd0, 1'b1, 1, 6'b000000, 1);
    cyc(1'b1, 2'b10, 6'd0, 1'b1, 0, 6'b110000, 10);
    for (int i = 0; i < 20; i++) cyc(1'b1, 2'b10, 6'd0, 1'b1, -1, -1, 10);
    // reset recovers the halted instance and clears illegal
    cyc(1'b0, 2'b01, 6'd0, 1'b1, -1, 0, -1);
`ifdef MC_FSM_WAIT_EN
    // STR with three FETCH waits and two MEMWR waits
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'b01, 6'b011000, 1'b0, 0, 6'b000000, 0);
    cyc(1'b1, 2'b01, 6'b011000, 1'b1, 0, 6'b110000, 0);
    cyc(1'b1, 2'b01, 6'b011000, 1'b0, 1, 6'b000000, 1);
    cyc(1'b1, 2'b01, 6'b011000, 1'b0, 2, 6'b000000, 2);
    for (int i = 0; i < 2; i++) cyc(1'b1, 2'b01, 6'b011000, 1'b0, 5, 6'b000000, 5);
    cyc(1'b1, 2'b01, 6'b011000, 1'b1, 5, 6'b000101, 5);
`else
    cyc(1'b1, 2'b01, 6'b011000, 1'b1, 0, 6'b110000, 0);
`endif

    // randomized phase with occasional resets (including mid-instruction)
    rst_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (rst_left > 0) begin
        r = 1'b0; rst_left--;
      end else if ($urandom_range(0, 79) == 0) begin
        r = 1'b0; rst_left = $urandom_range(0, 2);
      end else begin
        r = 1'b1;
      end
      pick = $urandom_range(0, 99);
      cyc(r, (pick < 8) ? 2'b11 : 2'($urandom_range(0, 2)), 6'($urandom),
          WAIT_EN ? ($urandom_range(0, 3) != 0) : 1'b1, -1, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
